// File: rtl/qc_inverse_rotator.sv
// Iterative inverse circular shifter: rotates a Z-bit sub-vector left by shift_val
// within a runtime lifting size Z, one binary-weighted stage per cycle.
module qc_inverse_rotator #(
    parameter int MAXZ = 81,
    parameter int SW   = $clog2(MAXZ)
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            valid_in,
    output logic            ready_in,
    input  logic [MAXZ-1:0] in_data,
    input  logic [SW-1:0]   shift_val,
    input  logic [SW-1:0]   z_size,
    output logic            valid_out,
    input  logic            ready_out,
    output logic [MAXZ-1:0] out_data,
    output logic            shift_err
);

    localparam int KW = (SW > 1) ? $clog2(SW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [MAXZ-1:0] vec_q;
    logic [SW-1:0]   shift_q;
    logic [SW-1:0]   z_q;
    logic [SW-1:0]   step_q;
    logic [KW-1:0]   k_q;
    logic            err_q;

    logic            accept;
    logic            last_stage;
    logic            in_illegal;
    logic [MAXZ-1:0] in_mask;
    logic [MAXZ-1:0] held_mask;
    logic [MAXZ-1:0] rot_vec;
    logic [SW:0]     step_dbl;
    logic [SW-1:0]   step_nxt;

    assign ready_in   = (state_q == IDLE) || ((state_q == DONE) && ready_out);
    assign valid_out  = (state_q == DONE);
    assign accept     = valid_in && ready_in;
    assign last_stage = (k_q == KW'(SW - 1));
    assign out_data   = vec_q;
    assign shift_err  = err_q;

    always_comb begin
        in_illegal = (z_size == '0) || (int'(z_size) > MAXZ) || (shift_val >= z_size);
        for (int i = 0; i < MAXZ; i++) begin
            in_mask[i]   = (i < int'(z_size));
            held_mask[i] = (i < int'(z_q));
        end
    end

    // step_q tracks 2^k mod Z; the held vector has no bits at or above Z, so the
    // right shift by (Z - step) wraps exactly the bits that leave the top of the ring.
    always_comb begin
        rot_vec  = ((vec_q << step_q) | (vec_q >> (z_q - step_q))) & held_mask;
        step_dbl = {step_q, 1'b0};
        if (step_dbl >= {1'b0, z_q}) begin
            step_dbl = step_dbl - {1'b0, z_q};
        end
        step_nxt = step_dbl[SW-1:0];
    end

    // NOTE: every variable assigned in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (last_stage) state_d = DONE;
            DONE: if (ready_out) state_d = accept ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the data register is reset too, because out_data must read zero during reset.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            vec_q   <= '0;
            shift_q <= '0;
            z_q     <= '0;
            step_q  <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            vec_q   <= in_illegal ? in_data : (in_data & in_mask);
            shift_q <= shift_val;
            z_q     <= z_size;
            step_q  <= (z_size == SW'(1)) ? '0 : SW'(1);
            k_q     <= '0;
            err_q   <= in_illegal;
        end else if (state_q == BUSY) begin
            // Illegal beats still walk all stages so latency is identical.
            if (!err_q && shift_q[k_q]) begin
                vec_q <= rot_vec;
            end
            step_q <= step_nxt;
            k_q    <= k_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_qc_inverse_rotator.sv
// Self-checking bench for qc_inverse_rotator: index-formula reference model,
// per-cycle scoreboard compare, directed corner cases and randomized traffic.
module tb_qc_inverse_rotator;

    localparam int MAXZ = 81;
    localparam int SW   = $clog2(MAXZ);

    typedef struct {
        logic [MAXZ-1:0] data;
        logic            err;
        int              acc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_in;
    logic            ready_in;
    logic [MAXZ-1:0] in_data;
    logic [SW-1:0]   shift_val;
    logic [SW-1:0]   z_size;
    logic            valid_out;
    logic            ready_out;
    logic [MAXZ-1:0] out_data;
    logic            shift_err;

    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              last_acc = 0;
    bit              prev_vo = 1'b0;
    exp_t            sb[$];
    logic [MAXZ-1:0] exp_data;
    logic            exp_err;

    qc_inverse_rotator #(.MAXZ(MAXZ), .SW(SW)) dut (
        .CLK       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .in_data   (in_data),
        .shift_val (shift_val),
        .z_size    (z_size),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .out_data  (out_data),
        .shift_err (shift_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // out[i] = in[(i - s) mod z] for i < z; illegal requests pass through untouched.
    function automatic exp_t model(input logic [MAXZ-1:0] d, input int s, input int z);
        exp_t e;
        e.data = '0;
        e.err  = 1'b0;
        e.acc  = 0;
        if (z < 1 || z > MAXZ || s >= z) begin
            e.err  = 1'b1;
            e.data = d;
        end else begin
            for (int i = 0; i < z; i++) e.data[i] = d[(i - s + z) % z];
        end
        return e;
    endfunction

    function automatic logic [MAXZ-1:0] rot_right(input logic [MAXZ-1:0] x, input int s);
        logic [MAXZ-1:0] r;
        for (int i = 0; i < MAXZ; i++) r[i] = x[(i + s) % MAXZ];
        return r;
    endfunction

    function automatic logic [MAXZ-1:0] rand_vec();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[MAXZ-1:0];
    endfunction

    // Scoreboard: checks every DONE cycle against the queue head, then records accepts.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_vo = 1'b0;
        end else begin
            if (valid_out) begin
                if (sb.size() == 0) begin
                    check("spurious_valid_out", valid_out, 1'b0);
                end else begin
                    check("out_data", out_data, sb[0].data);
                    check("shift_err", shift_err, sb[0].err);
                    check("ready_in_done", ready_in, ready_out);
                    if (!prev_vo) check("latency", cyc, sb[0].acc + SW);
                    if (ready_out) void'(sb.pop_front());
                end
            end else begin
                check("ready_in", ready_in, sb.size() == 0);
            end
            if (valid_in && ready_in) begin
                sb.push_back('{data: exp_data, err: exp_err, acc: cyc + 1});
                last_acc = cyc + 1;
            end
            prev_vo = valid_out;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [MAXZ-1:0] d, input int s, input int z,
                        input logic [MAXZ-1:0] ed, input logic ee, output int waits);
        valid_in  = 1'b1;
        in_data   = d;
        shift_val = SW'(s);
        z_size    = SW'(z);
        exp_data  = ed;
        exp_err   = ee;
        waits     = 0;
        while (1) begin
            @(negedge clk);
            if (ready_in) break;
            waits++;
            if (waits > 200) begin
                check("accept_timeout", waits, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !valid_out) break;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic directed(input string name, input logic [MAXZ-1:0] d, input int s,
                            input int z, input logic [MAXZ-1:0] lit_data, input logic lit_err);
        exp_t e;
        int   w;
        e = model(d, s, z);
        check({"model_data_", name}, e.data, lit_data);
        check({"model_err_", name}, e.err, lit_err);
        send(d, s, z, lit_data, lit_err, w);
    endtask

    initial begin
        int              w;
        int              prev_acc;
        logic [MAXZ-1:0] x;
        logic [MAXZ-1:0] pat;
        exp_t            e;

        rst_n     = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        in_data   = '0;
        shift_val = '0;
        z_size    = '0;
        exp_data  = '0;
        exp_err   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_ready_in", ready_in, 1'b1);
        check("rst_out_data", out_data, '0);
        check("rst_shift_err", shift_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed corner cases with hand-computed results.
        pat = 81'h1_2345_6789_ABCD_EF01_2345;
        directed("bit0_s5", 81'd1, 5, 81, 81'd32, 1'b0);
        directed("wrap_z27", (81'd1 << 26) | (81'd1 << 40), 1, 27, 81'd1, 1'b0);
        directed("ones_z54_s0", {MAXZ{1'b1}}, 0, 54, {27'd0, {54{1'b1}}}, 1'b0);
        directed("illegal_s30", pat, 30, 27, pat, 1'b1);
        directed("illegal_z0", pat, 0, 0, pat, 1'b1);
        directed("illegal_z100", pat, 3, 100, pat, 1'b1);
        directed("z1_s0", 81'h3, 0, 1, 81'd1, 1'b0);
        directed("msb_wrap", 81'd1 << 80, 80, 81, 81'd1 << 79, 1'b0);
        drain();

        // Backpressure: output held, then a new beat accepted on the releasing edge.
        @(posedge clk);
        #1;
        ready_out = 1'b0;
        send(81'd1 << 3, 4, 10, 81'd1 << 7, 1'b0, w);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (valid_out) break;
        end
        repeat (5) @(negedge clk);
        check("bp_ready_in", ready_in, 1'b0);
        check("bp_hold_data", out_data, 81'd1 << 7);
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        e = model(pat, 17, 81);
        send(pat, 17, 81, e.data, e.err, w);
        check("bp_same_edge_accept", w, 0);
        drain();

        // Reset in the middle of BUSY discards the beat.
        @(posedge clk);
        #1;
        e = model(pat, 9, 40);
        send(pat, 9, 40, e.data, e.err, w);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_valid_out", valid_out, 1'b0);
        check("midrst_out_data", out_data, '0);
        check("midrst_ready_in", ready_in, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        e = model(pat, 2, 33);
        send(pat, 2, 33, e.data, e.err, w);
        check("post_rst_accept", w, 0);
        drain();

        // Round trip: right-rotated vectors must come back as the original.
        @(posedge clk);
        #1;
        prev_acc = 0;
        for (int i = 0; i < 101; i++) begin
            x = rand_vec();
            begin
                int s;
                s = $urandom_range(0, MAXZ - 1);
                send(rot_right(x, s), s, MAXZ, x, 1'b0, w);
            end
            if (i > 0) check("rt_throughput", last_acc - prev_acc, SW + 1);
            prev_acc = last_acc;
        end
        drain();

        // Random traffic with random backpressure against the model.
        begin
            int sent;
            bit pend;
            sent = 0;
            pend = 1'b0;
            for (int c = 0; c < 6000 && (sent < 150 || pend); c++) begin
                @(posedge clk);
                #1;
                if (!pend) valid_in = 1'b0;
                ready_out = ($urandom_range(0, 3) != 0);
                if (!pend && sent < 150 && $urandom_range(0, 1) == 1) begin
                    int z;
                    int s;
                    if ($urandom_range(0, 9) == 0) z = $urandom_range(0, 127);
                    else z = $urandom_range(1, MAXZ);
                    if (z > 0 && $urandom_range(0, 7) != 0) s = $urandom_range(0, z - 1);
                    else s = $urandom_range(0, 127);
                    x = rand_vec();
                    e = model(x, s, z);
                    valid_in  = 1'b1;
                    in_data   = x;
                    shift_val = SW'(s);
                    z_size    = SW'(z);
                    exp_data  = e.data;
                    exp_err   = e.err;
                    pend      = 1'b1;
                end
                @(negedge clk);
                if (pend && valid_in && ready_in) begin
                    pend = 1'b0;
                    sent++;
                end
            end
            check("rand_beats_sent", sent, 150);
        end
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qc_inverse_rotator.md
# qc_inverse_rotator

Iterative inverse circular shifter for the QC-LDPC datapath. It undoes the right-rotation applied by `pipelinedCircularShifter` / `pipelinedCircularShifterFMAX`: it rotates a Z-bit sub-vector left by the same shift value, within a runtime lifting size Z ≤ MAXZ. It sits on the return path of the decoder, between the check-node output and the variable-node memory, and uses a valid/ready handshake on both sides.

## Interface

Parameters:
- `MAXZ`, 81, maximum lifting size (data width).
- `SW`, `$clog2(MAXZ)` (7), width of the shift and Z fields; also the number of rotate stages.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `valid_in`  in  1  input beat valid.
- `ready_in`  out  1  block can accept a beat.
- `in_data`  in  MAXZ  rotated vector; bits ≥ z_size are ignored.
- `shift_val`  in  SW  original right-shift amount to undo.
- `z_size`  in  SW  lifting size Z; legal range 1..MAXZ.
- `valid_out`  out  1  output beat valid.
- `ready_out`  in  1  downstream accepts the output.
- `out_data`  out  MAXZ  de-rotated vector.
- `shift_err`  out  1  qualifies the output beat; set when the request was illegal.

## Operation

- Transfers:
  - Accept on a rising edge with `valid_in && ready_in`.
  - Output transfer on a rising edge with `valid_out && ready_out`.
- States:
  - **IDLE**: `ready_in`=1, `valid_out`=0. On accept:
    - Capture `in_data` masked to its low z_size bits, plus `shift_val` and `z_size`.
    - Clear the stage counter k.
    - Go to BUSY.
  - **BUSY**: on each edge, if `shift_val[k]`=1, rotate the held vector left by (2^k mod z_size) within the low z_size bits; then k++. After stage k=SW-1, go to DONE.
  - **DONE**: `valid_out`=1; `out_data` and `shift_err` are held stable.
    - Output transfer with no new accept: go to IDLE.
    - `ready_in` = `ready_out` in DONE. If an accept occurs on the same edge as the output transfer, capture the new beat and go directly to BUSY.
- Function for a legal request (1 ≤ z_size ≤ MAXZ and shift_val < z_size):
  - out_data[i] = in_data[(i − shift_val) mod z_size] for i < z_size.
  - out_data[i] = 0 for i ≥ z_size.
- Illegal request (z_size = 0, z_size > MAXZ, or shift_val ≥ z_size):
  - `shift_err`=1.
  - `out_data` = `in_data` unmasked and unrotated.
  - The beat still passes through BUSY with identical latency.
- shift_val = 0: output is the masked input.
- Round trip: with z_size = MAXZ, out_data == x when in_data = rot_right(x, s) for every s in 0..MAXZ-1.

## Timing

- Reset values while `rst_n`=0:
  - State IDLE.
  - `valid_out`=0, `out_data`=0, `shift_err`=0, k=0.
  - `ready_in`=1, since it is decoded from the IDLE state.
  - Benches must hold `valid_in`=0 during reset.
- Reset asserted mid-operation, in BUSY or DONE: the beat is discarded immediately and asynchronously; no output is produced for it.
- Latency: for an accept at edge E, `valid_out` rises after edge E+SW (7 edges at default).
- Throughput:
  - One beat per SW+1 cycles under a continuous `ready_out` with back-to-back `valid_in`.
  - SW+2 cycles if the next beat arrives after the block returns to IDLE.
- Backpressure: while `ready_out`=0 in DONE, the output holds indefinitely and `ready_in`=0.
- `ready_in` depends combinationally on `ready_out` in DONE only; there is no other input-to-output combinational path.

## Test plan

- z_size=81, in_data=1 (bit0 only), shift_val=5 → out_data has only bit5 set, shift_err=0, `valid_out` high 7 edges after accept.
- z_size=27, in_data has bits 26 and 40 set, shift_val=1 → out_data has only bit0 set (wrap-around within Z; bit 40 masked off).
- z_size=54, in_data=all ones, shift_val=0 → out_data low 54 bits = 1, high 27 bits = 0; z_size=27, shift_val=30 → shift_err=1, out_data = in_data unchanged, same latency.
- Backpressure: hold `ready_out`=0 for 5 cycles after `valid_out` rises → out_data stable, `ready_in`=0. Raise `ready_out` with a new beat presented → new beat accepted on that same edge, next `valid_out` 7 edges later.
- Reset: assert `rst_n`=0 three cycles into BUSY → `valid_out`=0 and out_data=0 immediately; after release, the block accepts on the first valid beat.
- Round trip: 101 random vectors at z_size=81 from `pipelinedCircularShifter` (ROTATES_PER_CYCLE=2) chained into this block → every output equals the original vector, zero failures.
